// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the byte-serial memory copy engine:
// default widths and the 2-bit FSM state encoding.
package mem_copy_dma_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mem_copy_dma_if.sv
// Memory control bus of the copy engine; the bidirectional data bus is a
// separate inout port because it is resolved through per-bit tristate cells.
interface mem_copy_dma_if
   import mem_copy_dma_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              mem_enable;
   logic              mem_re_L;
   logic              mem_we_L;
   logic [ADDR_W-1:0] mem_address;

   modport master (output mem_enable, output mem_re_L, output mem_we_L, output mem_address);
   modport slave  (input  mem_enable, input  mem_re_L, input  mem_we_L, input  mem_address);

endinterface

// File: rtl/mem_copy_dma_tristate.sv
// Single-bit tristate pad driver: drives the pad with data_i when oe_i is
// high, otherwise releases it to high impedance.
module triState (
   input  logic data_i,
   input  logic oe_i,
   output wire  pad_o
);

   assign pad_o = oe_i ? data_i : 1'bz;

endmodule

// File: rtl/mem_copy_dma.sv
// Byte-serial memory-to-memory copy engine: one READ cycle then one WRITE
// cycle per byte, ascending addresses, abortable, async active-high reset.
module mem_copy_dma
   import mem_copy_dma_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    src_addr,
   input  logic [ADDR_W-1:0]    dst_addr,
   input  logic [ADDR_W-1:0]    length,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W-1:0]    bytes_done,
   mem_copy_dma_if.master       mem,
   inout  wire  [DATA_W-1:0]    mem_data
);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [ADDR_W-1:0] cnt_inc;
   logic              drive_en;

   assign cnt_inc = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  len_d   = length;
                  cnt_d   = '0;
                  state_d = ST_READ;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_READ: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               hold_d  = mem_data;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // The write in flight always completes; abort only suppresses the rest.
            cnt_d = cnt_inc;
            if (abort)                 state_d = ST_IDLE;
            else if (cnt_inc == len_q) state_d = ST_DONE;
            else                       state_d = ST_READ;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   // Bus outputs decode purely from state so reset takes effect without a clock edge.
   always_comb begin
      mem.mem_enable  = 1'b0;
      mem.mem_re_L    = 1'b1;
      mem.mem_we_L    = 1'b1;
      mem.mem_address = '0;
      case (state_q)
         ST_READ: begin
            mem.mem_enable  = 1'b1;
            mem.mem_re_L    = 1'b0;
            mem.mem_address = src_q + cnt_q;
         end
         ST_WRITE: begin
            mem.mem_enable  = 1'b1;
            mem.mem_we_L    = 1'b0;
            mem.mem_address = dst_q + cnt_q;
         end
         default: ;
      endcase
   end

   assign busy       = (state_q == ST_READ) || (state_q == ST_WRITE);
   assign done       = (state_q == ST_DONE);
   assign bytes_done = cnt_q;
   assign drive_en   = (state_q == ST_WRITE);

   for (genvar i = 0; i < DATA_W; i++) begin : g_data_drv
      triState u_ts (
         .data_i (hold_q[i]),
         .oe_i   (drive_en),
         .pad_o  (mem_data[i])
      );
   end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Randomized scoreboard bench for mem_copy_dma with a memory model, a
// byte-sequential reference copy and a decoupled bus monitor.
module tb_mem_copy_dma;

   localparam int AW = 16;
   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [AW-1:0] length = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] bytes_done;
   wire  [DW-1:0] mem_data;

   mem_copy_dma_if #(.ADDR_W(AW)) mif ();

   mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .bytes_done (bytes_done),
      .mem        (mif),
      .mem_data   (mem_data)
   );

   always #5 clock = ~clock;

   // Memory model: combinational read, write on posedge, plus a backdoor port.
   logic [DW-1:0] mem     [0:65535];
   logic [DW-1:0] ref_mem [0:65535];
   logic          bd_we   = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [DW-1:0] bd_data = '0;

   always @(posedge clock) begin
      if (bd_we)
         mem[bd_addr] <= bd_data;
      else if (mif.mem_enable && !mif.mem_we_L)
         mem[mif.mem_address] <= mem_data;
   end

   assign mem_data = (mif.mem_enable && !mif.mem_re_L) ? mem[mif.mem_address] : 'z;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           exp_wr[$];
   logic [AW-1:0] exp_rd[$];
   int checks = 0;
   int failures = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   int en_cnt = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   // Bus monitor / scoreboard consumer
   always @(negedge clock) begin
      if (busy)           busy_cnt++;
      if (done)           done_cnt++;
      if (mif.mem_enable) en_cnt++;
      if (!mif.mem_re_L && !mif.mem_we_L) check("strobe_overlap", 32'd1, 32'd0);
      check("busy_vs_strobes", {31'd0, busy}, {31'd0, (!mif.mem_re_L || !mif.mem_we_L)});
      if (mif.mem_enable && !mif.mem_re_L) begin
         if (exp_rd.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_read actual=%0h required=none", mif.mem_address);
         end else begin
            check("read_addr", 32'(mif.mem_address), 32'(exp_rd.pop_front()));
         end
      end
      if (mif.mem_enable && !mif.mem_we_L) begin
         if (exp_wr.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write actual=%0h required=none", mif.mem_address);
         end else begin
            wr_t e;
            e = exp_wr.pop_front();
            check("write_addr", 32'(mif.mem_address), 32'(e.a));
            check("write_data", 32'(mem_data), 32'(e.d));
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},       {31'd0, busy},            32'd0);
      check({tag, "_done"},       {31'd0, done},            32'd0);
      check({tag, "_bytes_done"}, 32'(bytes_done),          32'd0);
      check({tag, "_enable"},     {31'd0, mif.mem_enable},  32'd0);
      check({tag, "_re_L"},       {31'd0, mif.mem_re_L},    32'd1);
      check({tag, "_we_L"},       {31'd0, mif.mem_we_L},    32'd1);
      check({tag, "_address"},    32'(mif.mem_address),     32'd0);
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clock);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = d;
      ref_mem[a] = d;
   endtask

   task automatic preload_end();
      @(negedge clock);
      bd_we = 1'b0;
      #1;
   endtask

   task automatic preload_rand(input logic [AW-1:0] a, input int n);
      for (int i = 0; i < n; i++) preload(AW'(a + i), DW'($urandom));
   endtask

   // abort_k: abort during the k-th WRITE; rst_k: reset during the k-th READ
   task automatic copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int l,
                       input int abort_k, input int rst_k, input bit glitch);
      int n_wr, n_rd, b0, d0, e0, nrd, nwr, exp_busy;
      bit fin;
      n_wr = l;
      n_rd = l;
      if (abort_k > 0) begin n_wr = abort_k;   n_rd = abort_k; end
      if (rst_k > 0)   begin n_wr = rst_k - 1; n_rd = rst_k;   end
      // Reference copy: byte i is read after all earlier bytes are written.
      for (int i = 0; i < n_rd; i++) exp_rd.push_back(AW'(s + i));
      for (int i = 0; i < n_wr; i++) begin
         wr_t e;
         e.a = AW'(d + i);
         e.d = ref_mem[AW'(s + i)];
         exp_wr.push_back(e);
         ref_mem[e.a] = e.d;
      end
      b0 = busy_cnt; d0 = done_cnt; e0 = en_cnt;
      start = 1'b1; src_addr = s; dst_addr = d; length = AW'(l);
      step();
      start = 1'b0; src_addr = AW'($urandom); dst_addr = AW'($urandom); length = AW'($urandom);
      nrd = 0; nwr = 0; fin = 1'b0;
      for (int c = 0; c < 2 * l + 20; c++) begin
         if (!busy && !done) begin fin = 1'b1; break; end
         if (!mif.mem_re_L) nrd++;
         if (!mif.mem_we_L) nwr++;
         abort = (abort_k > 0) && !mif.mem_we_L && (nwr == abort_k);
         start = glitch && (nwr == 1) && !mif.mem_re_L;
         if (start) begin src_addr = AW'(s + 100); dst_addr = AW'(d + 50); length = 16'd1; end
         if (rst_k > 0 && !mif.mem_re_L && nrd == rst_k) begin
            reset = 1'b1;
            #1;
            check_reset_outputs("midread_reset");
            step();
            step();
            reset = 1'b0;
            fin = 1'b1;
            break;
         end
         step();
      end
      abort = 1'b0;
      start = 1'b0;
      check("copy_finished", {31'd0, fin}, 32'd1);
      exp_busy = (rst_k > 0) ? 2 * (rst_k - 1) + 1 : 2 * n_wr;
      check("busy_cycles", 32'(busy_cnt - b0), 32'(exp_busy));
      check("done_pulses", 32'(done_cnt - d0), (abort_k > 0 || rst_k > 0) ? 32'd0 : 32'd1);
      if (l == 0) check("len0_enable_cycles", 32'(en_cnt - e0), 32'd0);
      else        check("bytes_done", 32'(bytes_done), (rst_k > 0) ? 32'd0 : 32'(n_wr));
      check("pending_writes", 32'(exp_wr.size()), 32'd0);
      check("pending_reads",  32'(exp_rd.size()), 32'd0);
      exp_wr.delete();
      exp_rd.delete();
      for (int i = 0; i < l; i++)
         check("dst_mem", 32'(mem[AW'(d + i)]), 32'(ref_mem[AW'(d + i)]));
   endtask

   initial begin
      #1 reset = 1'b1;
      #1 check_reset_outputs("por");
      step();
      step();
      reset = 1'b0;
      step();

      // Directed four-byte copy with known contents
      preload(16'h0100, 8'h11); preload(16'h0101, 8'h22);
      preload(16'h0102, 8'h33); preload(16'h0103, 8'h44);
      preload_rand(16'h0200, 4);
      preload_end();
      copy(16'h0100, 16'h0200, 4, 0, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         check("basic_dst_const", 32'(mem[16'h0200 + i]), 32'(8'h11 * (i + 1)));

      // Zero-length request
      copy(16'h0300, 16'h0400, 0, 0, 0, 1'b0);

      // Address wrap on both source and destination
      preload_rand(16'hFFFF, 2);
      preload_rand(16'h7FFF, 2);
      preload_end();
      copy(16'hFFFF, 16'h7FFF, 2, 0, 0, 1'b0);

      // Abort during the second write of a five-byte copy
      preload_rand(16'h1000, 5);
      preload_rand(16'h2000, 5);
      preload_end();
      copy(16'h1000, 16'h2000, 5, 2, 0, 1'b0);

      // Reset during the second read
      preload_rand(16'h3000, 3);
      preload_rand(16'h4000, 3);
      preload_end();
      copy(16'h3000, 16'h4000, 3, 0, 2, 1'b0);
      check_reset_outputs("post_reset");

      // start re-asserted while busy
      preload_rand(16'h5000, 4);
      preload_rand(16'h6000, 4);
      preload_end();
      copy(16'h5000, 16'h6000, 4, 0, 0, 1'b1);

      // Randomized copies, including overlapping ascending ranges
      for (int t = 0; t < 10; t++) begin
         logic [AW-1:0] s, d;
         int l;
         s = AW'($urandom);
         d = ($urandom_range(0, 1) == 1) ? AW'(s + $urandom_range(1, 3)) : AW'($urandom);
         l = $urandom_range(1, 10);
         preload_rand(s, l);
         preload_rand(d, l);
         preload_end();
         copy(s, d, l, 0, 0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter ADDR_W, default 16, is the memory address width in bits.
REQ-002 Parameter DATA_W, default 8, is the memory data width in bits.
REQ-003 Port clock  input  1  is the single system clock; all state changes on its posedge.
REQ-004 Port reset  input  1  is the reset: asynchronous, active-high.
REQ-005 Port start  input  1  requests a copy; sampled only in IDLE.
REQ-006 Port src_addr  input  ADDR_W  is the first source byte address.
REQ-007 Port dst_addr  input  ADDR_W  is the first destination byte address.
REQ-008 Port length  input  ADDR_W  is the byte count; 0 means no transfer.
REQ-009 Port abort  input  1  terminates a copy in progress.
REQ-010 Port busy  output  1  is high while a copy is in progress.
REQ-011 Port done  output  1  is a one-cycle pulse on normal completion.
REQ-012 Port bytes_done  output  ADDR_W  counts bytes written in the current or last copy.
REQ-013 Port mem_enable  output  1  is the memory chip enable.
REQ-014 Port mem_re_L  output  1  is the active-low read strobe; memory read is combinational.
REQ-015 Port mem_we_L  output  1  is the active-low write strobe; memory latches on posedge clock.
REQ-016 Port mem_address  output  ADDR_W  is the memory address.
REQ-017 Port mem_data  inout  DATA_W  is the shared bidirectional memory data bus.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, READ, WRITE, DONE.
REQ-019 IDLE with start=1 and length!=0 SHALL latch src_addr, dst_addr and length, clear bytes_done, and go to READ.
REQ-020 IDLE with start=1 and length=0 SHALL go to DONE with no memory access.
REQ-021 In READ, outputs SHALL be mem_enable=1, mem_re_L=0, mem_we_L=1, mem_address=src+bytes_done, and mem_data SHALL be high-Z.
REQ-022 The posedge leaving READ SHALL capture mem_data into a DATA_W hold register, then go to WRITE.
REQ-023 In WRITE, outputs SHALL be mem_enable=1, mem_re_L=1, mem_we_L=0, mem_address=dst+bytes_done, and mem_data SHALL be driven with the hold register.
REQ-024 The posedge leaving WRITE SHALL increment bytes_done.
REQ-025 After that edge, the FSM SHALL go to DONE if bytes_done+1 equals the latched length, else to READ.
REQ-026 Each byte SHALL take exactly 2 cycles; a copy of N bytes SHALL hold busy high for 2N cycles.
REQ-027 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-028 busy SHALL be 1 in READ and WRITE only.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_W; source 16'hFFFF is followed by 16'h0000.
REQ-030 start SHALL be ignored outside IDLE.
REQ-031 abort=1 in READ SHALL go to IDLE on that edge with no write and no done pulse.
REQ-032 abort=1 in WRITE SHALL let the current write complete and increment bytes_done, then go to IDLE without a done pulse.
REQ-033 abort SHALL take priority over the transition to DONE.
REQ-034 mem_re_L and mem_we_L SHALL never both be 0.
REQ-035 mem_data SHALL be driven only in WRITE.
REQ-036 Overlapping source and destination ranges SHALL be copied in ascending address order with no hazard detection.

Reset
REQ-037 Asserting reset SHALL immediately force IDLE, including mid-copy; no partial write SHALL occur after assertion.
REQ-038 During reset, outputs SHALL be: busy=0, done=0, bytes_done=0, mem_enable=0, mem_re_L=1, mem_we_L=1, mem_address=0, mem_data high-Z.
REQ-039 Hold register and latched parameters SHALL reset to 0.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, READ=1, WRITE=2, DONE=3) and the ADDR_W/DATA_W defaults.
REQ-041 The mem_data driver SHALL be the existing triState cell, one instance per bit; there are no other sub-modules.

Verification
REQ-042 With memory[0x0100..0x0103]=11,22,33,44, start src=0x0100, dst=0x0200, len=4: memory[0x0200..0x0203]=11,22,33,44, busy high 8 cycles, one done pulse, bytes_done=4.
REQ-043 start with len=0: done pulses on the next cycle, mem_enable stays 0, busy never rises.
REQ-044 src=0xFFFF, dst=0x7FFF, len=2: reads hit 0xFFFF then 0x0000, writes hit 0x7FFF then 0x8000.
REQ-045 abort asserted in the second WRITE of a len=5 copy: exactly 2 bytes are written, bytes_done=2, no done pulse, next state IDLE.
REQ-046 reset asserted mid-READ: outputs reach reset values with no clock edge, and the destination is unchanged for that byte.
REQ-047 start re-asserted while busy: ignored, and the original copy completes unchanged; a bus monitor flags any cycle with re_L=we_L=0 or mem_data driven outside WRITE.
